// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: NUM_REQ requesters share one valid/ready channel, each grant capped at MAX_BURST beats.
// Optional embedded assertions/covers are compiled in with `define RR_ARB_FORMAL_CHECKS_EN.

module rr_burst_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              i_sel,
  input  logic              i_req,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic              o_gnt,
  output logic [DATA_W-1:0] o_data
);
  // Data is gated by the select so non-owner payloads never reach the output OR tree.
  assign o_vld  = i_sel & i_req;
  assign o_gnt  = o_vld & i_ready;
  assign o_data = o_vld ? i_data : '0;
endmodule

module rr_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [OW-1:0]             out_owner,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  logic [2*NUM_REQ-1:0]             w_dbl;
  logic [OW-1:0]                    w_off;
  logic [OW:0]                      w_sum;
  logic [OW-1:0]                    w_win;
  logic [NUM_REQ-1:0]               w_sel;
  logic [NUM_REQ-1:0]               w_vld;
  logic [NUM_REQ-1:0][DATA_W-1:0]   w_lane_data;
  logic                             w_own_req;
  logic                             w_last;
  logic                             w_xfer;
  logic                             w_rel;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  assign w_dbl = {req, req} >> r_ptr;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_dbl[k]) w_off = OW'(k);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= (OW+1)'(NUM_REQ)) ? OW'(w_sum - (OW+1)'(NUM_REQ)) : OW'(w_sum);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_sel[gi] = (r_state == GRANT) && (r_owner == OW'(gi));
      rr_burst_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
        .i_sel   (w_sel[gi]),
        .i_req   (req[gi]),
        .i_ready (out_ready),
        .i_data  (req_data[gi*DATA_W +: DATA_W]),
        .o_vld   (w_vld[gi]),
        .o_gnt   (gnt[gi]),
        .o_data  (w_lane_data[gi])
      );
    end
  endgenerate

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) out_data = out_data | w_lane_data[i];
  end

  assign out_valid = |w_vld;
  assign busy      = (r_state == GRANT);
  assign out_owner = r_owner;
  assign w_own_req = |(w_sel & req);
  assign w_last    = |(w_sel & req_last);
  assign w_xfer    = out_valid & out_ready;
  assign w_rel     = !w_own_req || (w_xfer && (w_last || (r_cnt == CW'(MAX_BURST - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_owner <= w_win;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_rel) begin
            // Releasing owner drops to lowest priority for the next arbitration.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);
          end else if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RR_ARB_FORMAL_CHECKS_EN
  default disable iff (!rst_n);

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_owner:  assert property (@(posedge clk)
    (gnt != '0) |-> ((r_state == GRANT) && (gnt == (NUM_REQ'(1) << r_owner))));
  a_valid_busy: assert property (@(posedge clk) out_valid |-> busy);
  a_cnt_range:  assert property (@(posedge clk) r_cnt < CW'(MAX_BURST));
  a_owner_rng:  assert property (@(posedge clk) {1'b0, r_owner} < (OW+1)'(NUM_REQ));
  a_data_hold:  assert property (@(posedge clk)
    (out_valid && !out_ready) ##1 out_valid |-> $stable(out_data));

  c_forced: cover property (@(posedge clk)
    (r_state == GRANT) && w_xfer && !w_last && (r_cnt == CW'(MAX_BURST - 1)));

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_fchk
      c_gnt: cover property (@(posedge clk) gnt[gi]);
`ifdef FORMAL
      m_data_stable: assume property (@(posedge clk)
        (w_sel[gi] && req[gi] && !gnt[gi]) |=> $stable(req_data[gi*DATA_W +: DATA_W]));
`endif
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized + directed bench for rr_burst_arbiter against a transaction-level reference model.
module tb_rr_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_last, gnt;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_ready, busy;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_owner;

  always #5 clk = ~clk;

  rr_burst_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_owner(out_owner), .busy(busy)
  );

  int checks = 0, errors = 0;

  // Reference model: granted flag, owner, rotation pointer, beats sent in current grant.
  int m_st = 0, m_own = 0, m_ptr = 0, m_cnt = 0;

  // Burst tracker built from observed DUT outputs.
  bit t_busy = 1'b0;
  int t_own = 0, t_len = 0, n_xfer = 0;
  int q_own[$], q_len[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    int i;
    if (m_st == 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (r[i]) begin
          m_own = i; m_st = 1; m_cnt = 0;
          break;
        end
      end
    end else if (!r[m_own] || (rdy && (l[m_own] || (m_cnt + 1 == MB)))) begin
      m_st = 0; m_ptr = (m_own + 1) % N; m_cnt = 0;
    end else if (rdy) begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                     input logic [N-1:0] l, input logic rdy);
    logic ev;
    logic [DW-1:0] ed;
    logic [N-1:0] eg;
    @(negedge clk);
    req = r; req_data = d; req_last = l; out_ready = rdy;
    #1;
    ev = (m_st == 1) && r[m_own];
    ed = ev ? d[m_own*DW +: DW] : '0;
    eg = (ev && rdy) ? (N'(1) << m_own) : '0;
    chk("busy",  32'(busy),      32'(m_st == 1));
    chk("valid", 32'(out_valid), 32'(ev));
    chk("data",  32'(out_data),  32'(ed));
    chk("gnt",   32'(gnt),       32'(eg));
    chk("owner", 32'(out_owner), 32'(m_own));
    if (busy) begin
      if (!t_busy) begin t_own = int'(out_owner); t_len = 0; end
      if (gnt != '0) begin t_len++; n_xfer++; end
    end else if (t_busy) begin
      q_own.push_back(t_own); q_len.push_back(t_len);
    end
    t_busy = busy;
    @(posedge clk);
    step(r, l, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_owner", 32'(out_owner), 32'd0);
    m_st = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    t_busy = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) cyc('0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [N-1:0]    r, l;
    logic [N*DW-1:0] d;
    int base, b;
    logic [DW-1:0] v;

    // Test 1: all requesting through reset, last on every beat.
    rst_n = 1'b0; req = '1; req_last = '1; out_ready = 1'b1; req_data = 32'h44332211;
    #1;
    chk("init_busy",  32'(busy),      32'd0);
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_gnt",   32'(gnt),       32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 11; k++) cyc('1, 32'h44332211, '1, 1'b1);
    flush();
    chk("t1_nburst", 32'(q_own.size() >= 5), 32'd1);
    if (q_own.size() >= 5) begin
      chk("t1_own0", 32'(q_own[0]), 32'd0);
      chk("t1_own1", 32'(q_own[1]), 32'd1);
      chk("t1_own2", 32'(q_own[2]), 32'd2);
      chk("t1_own3", 32'(q_own[3]), 32'd3);
      chk("t1_own4", 32'(q_own[4]), 32'd0);
    end

    // Test 2: 20-beat stream from requester 2, forced release every MB beats.
    q_own.delete(); q_len.delete(); base = n_xfer;
    for (int c = 0; c < 60 && (n_xfer - base) < 20; c++) begin
      b = n_xfer - base;
      cyc(4'b0100, {N{8'(b)}}, (b == 19) ? 4'b0100 : 4'b0000, 1'b1);
    end
    chk("t2_sent", 32'(n_xfer - base), 32'd20);
    flush();
    chk("t2_nburst", 32'(q_len.size()), 32'd3);
    if (q_len.size() == 3) begin
      chk("t2_len0", 32'(q_len[0]), 32'd8);
      chk("t2_len1", 32'(q_len[1]), 32'd8);
      chk("t2_len2", 32'(q_len[2]), 32'd4);
      chk("t2_own2", 32'(q_own[2]), 32'd2);
    end

    // Test 3: requester 1, ready toggling, 3 beats with last on the third.
    base = n_xfer;
    for (int c = 0; c < 20 && (n_xfer - base) < 3; c++) begin
      b = n_xfer - base;
      v = (b == 0) ? 8'h11 : (b == 1) ? 8'h22 : 8'h33;
      d = '0; d[DW +: DW] = v;
      cyc(4'b0010, d, (b == 2) ? 4'b0010 : 4'b0000, (c % 2) == 0);
    end
    chk("t3_sent", 32'(n_xfer - base), 32'd3);
    flush();

    // Test 4: requester 3 abandons mid-burst while requester 0 waits.
    q_own.delete(); q_len.delete();
    for (int k = 0; k < 3; k++) cyc(4'b1001, 32'hA5A5A5A5, '0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(4'b0001, 32'h5A5A5A5A, 4'b0001, 1'b1);
    flush();
    chk("t4_nburst", 32'(q_own.size() >= 2), 32'd1);
    if (q_own.size() >= 2) begin
      chk("t4_own0", 32'(q_own[0]), 32'd3);
      chk("t4_own1", 32'(q_own[1]), 32'd0);
    end

    // Test 5: reset mid-burst restarts arbitration from requester 0.
    for (int k = 0; k < 3; k++) cyc(4'b0010, 32'h00CC0000, '0, 1'b1);
    do_reset();
    q_own.delete(); q_len.delete();
    for (int k = 0; k < 3; k++) cyc('1, 32'h01020304, '1, 1'b1);
    flush();
    chk("t5_nburst", 32'(q_own.size() >= 1), 32'd1);
    if (q_own.size() >= 1) chk("t5_own0", 32'(q_own[0]), 32'd0);

    // Random traffic with occasional resets.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      l = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) l[i] = 1'b1;
      d = $urandom;
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc(r, d, l, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
